// File: rtl/triangle_rasterizer_if.sv
// Bundles the triangle-accept handshake and the fragment output stream of the
// triangle rasterizer.
//   slave  : rasterizer side (drives o_*, samples i_*)
//   master : assembler / downstream side (drives i_*, samples o_*)
// Coordinates are packed as [vertex][0=x,1=y]; edge values as [edge].
interface triangle_rasterizer_if #(
  parameter int IV_DATAWIDTH      = 12,
  parameter int IV_DEPTH_FRACBITS = 12,
  parameter int EDGE_W            = 2*IV_DATAWIDTH+3
) ();
  logic                                       o_ready;
  logic                                       i_dv;
  logic [2:0][1:0][IV_DATAWIDTH-1:0]          i_vertex_pixel;
  logic [2:0][IV_DEPTH_FRACBITS-1:0]          i_vertex_z;
  logic [1:0][IV_DATAWIDTH-1:0]               i_bb_tl;
  logic [1:0][IV_DATAWIDTH-1:0]               i_bb_br;
  logic                                       o_frag_valid;
  logic                                       i_frag_ready;
  logic [1:0][IV_DATAWIDTH-1:0]               o_frag_xy;
  logic [2:0][EDGE_W-1:0]                     o_frag_w;
  logic [EDGE_W-1:0]                          o_tri_area;
  logic [2:0][IV_DEPTH_FRACBITS-1:0]          o_tri_z;
  logic                                       o_tri_done;

  modport slave (
    output o_ready, o_frag_valid, o_frag_xy, o_frag_w, o_tri_area, o_tri_z, o_tri_done,
    input  i_dv, i_vertex_pixel, i_vertex_z, i_bb_tl, i_bb_br, i_frag_ready
  );

  modport master (
    input  o_ready, o_frag_valid, o_frag_xy, o_frag_w, o_tri_area, o_tri_z, o_tri_done,
    output i_dv, i_vertex_pixel, i_vertex_z, i_bb_tl, i_bb_br, i_frag_ready
  );
endinterface

// File: rtl/triangle_rasterizer.sv
// Triangle rasterizer: accepts one screen-space triangle with a clamped bbox,
// walks the bbox row-major evaluating the three edge functions incrementally,
// and streams one fragment per covered on-screen pixel, then pulses done.
// Ports:
//   clk, rstn : clock, synchronous active-low reset
//   bus       : triangle_rasterizer_if.slave (accept handshake, fragment
//               stream with sign-normalised edge weights, latched area/z, done)
//
// state  | meaning
// IDLE   | o_ready=1, waiting for a triangle
// SETUP  | compute area, step terms and edge values at bbox top-left
// WALK   | test one pixel per unstalled cycle
// DRAIN  | wait for the final fragment to leave the output register
// DONE   | one-cycle o_tri_done pulse
module triangle_rasterizer #(
  parameter int IV_DATAWIDTH      = 12,
  parameter int IV_DEPTH_FRACBITS = 12,
  parameter int SCREEN_WIDTH      = 320,
  parameter int SCREEN_HEIGHT     = 320
) (
  input logic                  clk,
  input logic                  rstn,
  triangle_rasterizer_if.slave bus
);
  localparam int DW     = IV_DATAWIDTH;
  localparam int EDGE_W = 2*IV_DATAWIDTH+3;
  localparam logic signed [DW-1:0] SW_L = DW'(SCREEN_WIDTH);
  localparam logic signed [DW-1:0] SH_L = DW'(SCREEN_HEIGHT);
  // edge k runs from vertex AI[k] to vertex BI[k]
  localparam int AI [3] = '{1, 2, 0};
  localparam int BI [3] = '{2, 0, 1};

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_WALK  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]                        state_q, state_d;
  logic [2:0][1:0][DW-1:0]           vtx_q;
  logic [1:0][DW-1:0]                tl_q, br_q;
  logic [2:0][IV_DEPTH_FRACBITS-1:0] z_q;
  logic [DW-1:0]                     x_q, y_q;
  logic [2:0][EDGE_W-1:0]            w_q, wrow_q, sx_q, sy_q;
  logic                              valid_q;
  logic [1:0][DW-1:0]                fxy_q;
  logic [2:0][EDGE_W-1:0]            fw_q;
  logic [EDGE_W-1:0]                 area_q;

  logic signed [EDGE_W-1:0] vx [3];
  logic signed [EDGE_W-1:0] vy [3];
  logic signed [EDGE_W-1:0] ex [3];
  logic signed [EDGE_W-1:0] ey [3];
  logic signed [EDGE_W-1:0] wr [3];
  logic signed [EDGE_W-1:0] tlx, tly, area_raw;
  logic [2:0][EDGE_W-1:0]   w_init, sx_init, sy_init;
  logic [EDGE_W-1:0]        area_abs;
  logic                     area_neg, discard;
  logic                     accept, adv, covered, in_screen, last_col, last_px;

  // Setup datapath: operands are sign-extended to EDGE_W first so the
  // products and their difference are exact.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      vx[k] = EDGE_W'($signed(vtx_q[k][0]));
      vy[k] = EDGE_W'($signed(vtx_q[k][1]));
    end
    tlx      = EDGE_W'($signed(tl_q[0]));
    tly      = EDGE_W'($signed(tl_q[1]));
    area_raw = (vx[1] - vx[0]) * (vy[2] - vy[0]) - (vy[1] - vy[0]) * (vx[2] - vx[0]);
    area_neg = area_raw[EDGE_W-1];
    area_abs = area_neg ? -area_raw : area_raw;
    for (int k = 0; k < 3; k++) begin
      ex[k] = vx[BI[k]] - vx[AI[k]];
      ey[k] = vy[BI[k]] - vy[AI[k]];
      wr[k] = ex[k] * (tly - vy[AI[k]]) - ey[k] * (tlx - vx[AI[k]]);
      // Negative winding: flip every term so coverage is always w >= 0.
      w_init[k]  = area_neg ? -wr[k] : wr[k];
      sx_init[k] = area_neg ? ey[k] : -ey[k];
      sy_init[k] = area_neg ? -ex[k] : ex[k];
    end
    discard = (area_raw == '0) || ($signed(tl_q[0]) > $signed(br_q[0]))
              || ($signed(tl_q[1]) > $signed(br_q[1]));
  end

  assign accept    = bus.i_dv && (state_q == S_IDLE);
  assign adv       = (state_q == S_WALK) && (!valid_q || bus.i_frag_ready);
  assign covered   = !w_q[0][EDGE_W-1] && !w_q[1][EDGE_W-1] && !w_q[2][EDGE_W-1];
  assign in_screen = ($signed(x_q) < SW_L) && ($signed(y_q) < SH_L);
  assign last_col  = (x_q == br_q[0]);
  assign last_px   = last_col && (y_q == br_q[1]);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.i_dv) state_d = S_SETUP;
      S_SETUP: state_d = discard ? S_DONE : S_WALK;
      S_WALK:  if (adv && last_px) state_d = S_DRAIN;
      S_DRAIN: if (!valid_q || bus.i_frag_ready) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      fxy_q   <= '0;
      fw_q    <= '0;
      area_q  <= '0;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        vtx_q <= bus.i_vertex_pixel;
        z_q   <= bus.i_vertex_z;
        tl_q  <= bus.i_bb_tl;
        br_q  <= bus.i_bb_br;
      end
      if (state_q == S_SETUP) begin
        area_q <= area_abs;
        x_q    <= tl_q[0];
        y_q    <= tl_q[1];
        w_q    <= w_init;
        wrow_q <= w_init;
        sx_q   <= sx_init;
        sy_q   <= sy_init;
      end
      if (adv) begin
        if (last_col) begin
          x_q <= tl_q[0];
          y_q <= y_q + DW'(1);
          for (int k = 0; k < 3; k++) begin
            wrow_q[k] <= wrow_q[k] + sy_q[k];
            w_q[k]    <= wrow_q[k] + sy_q[k];
          end
        end else begin
          x_q <= x_q + DW'(1);
          for (int k = 0; k < 3; k++) w_q[k] <= w_q[k] + sx_q[k];
        end
      end
      if (adv && covered && in_screen) begin
        valid_q  <= 1'b1;
        fxy_q[0] <= x_q;
        fxy_q[1] <= y_q;
        fw_q     <= w_q;
      end else if (valid_q && bus.i_frag_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.o_ready      = (state_q == S_IDLE);
  assign bus.o_frag_valid = valid_q;
  assign bus.o_frag_xy    = fxy_q;
  assign bus.o_frag_w     = fw_q;
  assign bus.o_tri_area   = area_q;
  assign bus.o_tri_z      = z_q;
  assign bus.o_tri_done   = (state_q == S_DONE);
endmodule

// File: tb/tb_triangle_rasterizer.sv
// Scoreboard bench for triangle_rasterizer: stimulus pushes hand-derived
// fragments, an independent monitor pops and compares on each handshake.
module tb_triangle_rasterizer;
  localparam int DW = 12;
  localparam int EW = 2*DW+3;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  triangle_rasterizer_if bus ();
  triangle_rasterizer dut (.clk(clk), .rstn(rstn), .bus(bus));

  typedef struct {int x; int y; int w0; int w1; int w2;} frag_t;
  frag_t sb[$];

  int n_tests = 0;
  int n_fail = 0;
  int pop_cnt = 0;
  int done_cnt = 0;
  int ready_mode = 0;
  logic stall_prev = 1'b0;
  logic [1:0][DW-1:0] s_xy;
  logic [2:0][EW-1:0] s_w;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int x, input int y, input int w0, input int w1, input int w2);
    frag_t f;
    f.x = x; f.y = y; f.w0 = w0; f.w1 = w1; f.w2 = w2;
    sb.push_back(f);
  endtask

  // Downstream ready: 0 = always ready, 1 = random 50%, other = never ready
  initial begin
    bus.i_frag_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.i_frag_ready = 1'b1;
        1:       bus.i_frag_ready = 1'($urandom_range(0, 1));
        default: bus.i_frag_ready = 1'b0;
      endcase
    end
  end

  // Monitor: sampled on the falling edge, away from the active edge
  initial begin
    frag_t e;
    int ax, ay, a0, a1, a2;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (stall_prev) begin
          n_tests++;
          if (bus.o_frag_valid !== 1'b1 || bus.o_frag_xy !== s_xy || bus.o_frag_w !== s_w) begin
            n_fail++;
            $display("FAIL stall_stable: got valid=%0b xy=%h w=%h, held xy=%h w=%h",
                     bus.o_frag_valid, bus.o_frag_xy, bus.o_frag_w, s_xy, s_w);
          end
        end
        stall_prev = bus.o_frag_valid && !bus.i_frag_ready;
        s_xy = bus.o_frag_xy;
        s_w  = bus.o_frag_w;
        if (bus.o_frag_valid && bus.i_frag_ready) begin
          ax = int'($signed(bus.o_frag_xy[0]));
          ay = int'($signed(bus.o_frag_xy[1]));
          a0 = int'($signed(bus.o_frag_w[0]));
          a1 = int'($signed(bus.o_frag_w[1]));
          a2 = int'($signed(bus.o_frag_w[2]));
          n_tests++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL frag_unexpected: got (%0d,%0d) w=(%0d,%0d,%0d), expected none",
                     ax, ay, a0, a1, a2);
          end else begin
            e = sb.pop_front();
            if (ax != e.x || ay != e.y || a0 != e.w0 || a1 != e.w1 || a2 != e.w2) begin
              n_fail++;
              $display("FAIL frag: got (%0d,%0d) w=(%0d,%0d,%0d), expected (%0d,%0d) w=(%0d,%0d,%0d)",
                       ax, ay, a0, a1, a2, e.x, e.y, e.w0, e.w1, e.w2);
            end
          end
          pop_cnt++;
        end
        if (bus.o_tri_done) done_cnt++;
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  task automatic set_tri(input int ax, input int ay, input int bx, input int by,
                         input int cx, input int cy, input int tx, input int ty,
                         input int rx, input int ry);
    bus.i_vertex_pixel[0][0] = DW'(ax); bus.i_vertex_pixel[0][1] = DW'(ay);
    bus.i_vertex_pixel[1][0] = DW'(bx); bus.i_vertex_pixel[1][1] = DW'(by);
    bus.i_vertex_pixel[2][0] = DW'(cx); bus.i_vertex_pixel[2][1] = DW'(cy);
    bus.i_bb_tl[0] = DW'(tx); bus.i_bb_tl[1] = DW'(ty);
    bus.i_bb_br[0] = DW'(rx); bus.i_bb_br[1] = DW'(ry);
  endtask

  // Returns #1 after the accepting clock edge
  task automatic send_tri();
    bit seen;
    seen = 1'b0;
    bus.i_dv = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.o_ready) begin seen = 1'b1; break; end
    end
    chk("accept_ready", longint'(seen), 1);
    @(posedge clk);
    #1;
    bus.i_dv = 1'b0;
    chk("tri_z0", longint'(bus.o_tri_z[0]), 'h123);
    chk("tri_z2", longint'(bus.o_tri_z[2]), 'h789);
  endtask

  task automatic wait_done(input int target, input string name);
    for (int i = 0; i < 600; i++) begin
      if (done_cnt >= target) break;
      @(posedge clk);
      #1;
    end
    chk(name, longint'(done_cnt >= target), 1);
  endtask

  task automatic push_t1();
    for (int y = 0; y <= 4; y++)
      for (int x = 0; x <= 4; x++)
        if (x + y <= 4) push(x, y, 16 - 4*x - 4*y, 4*x, 4*y);
  endtask

  task automatic run_t1(input string tag, input bit check_lat);
    int d0, p0;
    d0 = done_cnt; p0 = pop_cnt;
    push_t1();
    set_tri(0, 0, 4, 0, 0, 4, 0, 0, 4, 4);
    send_tri();
    if (check_lat) begin
      chk({tag, "_setup_valid"}, longint'(bus.o_frag_valid), 0);
      @(posedge clk); #1;
      chk({tag, "_walk0_valid"}, longint'(bus.o_frag_valid), 0);
      @(posedge clk); #1;
      chk({tag, "_first_valid"}, longint'(bus.o_frag_valid), 1);
    end
    wait_done(d0 + 1, {tag, "_done"});
    chk({tag, "_area"}, longint'(bus.o_tri_area), 16);
    chk({tag, "_count"}, longint'(pop_cnt - p0), 15);
    chk({tag, "_sb_empty"}, longint'(sb.size()), 0);
    chk({tag, "_done_pulse_1cyc"}, longint'(bus.o_tri_done), 0);
    chk({tag, "_ready_back"}, longint'(bus.o_ready), 1);
  endtask

  initial begin
    int d0, p0;
    bus.i_dv = 1'b0;
    bus.i_vertex_z[0] = 12'h123;
    bus.i_vertex_z[1] = 12'h456;
    bus.i_vertex_z[2] = 12'h789;
    set_tri(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    chk("rst_ready", longint'(bus.o_ready), 1);
    chk("rst_valid", longint'(bus.o_frag_valid), 0);
    chk("rst_done", longint'(bus.o_tri_done), 0);
    chk("rst_area", longint'(bus.o_tri_area), 0);
    chk("rst_xy", longint'(bus.o_frag_xy), 0);
    chk("rst_w", longint'(bus.o_frag_w), 0);
    chk("rst_z", longint'(bus.o_tri_z), 0);

    // 1: basic triangle, minimum latency
    run_t1("t1", 1'b1);

    // 2: opposite winding, weights for w1/w2 swap roles
    d0 = done_cnt; p0 = pop_cnt;
    for (int y = 0; y <= 4; y++)
      for (int x = 0; x <= 4; x++)
        if (x + y <= 4) push(x, y, 16 - 4*x - 4*y, 4*y, 4*x);
    set_tri(0, 0, 0, 4, 4, 0, 0, 0, 4, 4);
    send_tri();
    wait_done(d0 + 1, "t2_done");
    chk("t2_area", longint'(bus.o_tri_area), 16);
    chk("t2_count", longint'(pop_cnt - p0), 15);
    chk("t2_sb_empty", longint'(sb.size()), 0);

    // 3: degenerate triangle is discarded
    d0 = done_cnt; p0 = pop_cnt;
    set_tri(0, 0, 2, 2, 4, 4, 0, 0, 4, 4);
    send_tri();
    chk("t3_done_early", longint'(bus.o_tri_done), 0);
    @(posedge clk); #1;
    chk("t3_done_pulse", longint'(bus.o_tri_done), 1);
    @(posedge clk); #1;
    chk("t3_done_clear", longint'(bus.o_tri_done), 0);
    chk("t3_ready", longint'(bus.o_ready), 1);
    chk("t3_no_frags", longint'(pop_cnt - p0), 0);
    chk("t3_done_cnt", longint'(done_cnt - d0), 1);

    // 4: random backpressure
    ready_mode = 1;
    run_t1("t4", 1'b0);
    ready_mode = 0;
    @(posedge clk); #1;

    // 5: screen-edge clipping
    d0 = done_cnt; p0 = pop_cnt;
    push(318, 318, 160, 720, 720);
    push(319, 318, 120, 760, 720);
    push(318, 319, 120, 720, 760);
    push(319, 319,  80, 760, 760);
    set_tri(300, 300, 340, 300, 300, 340, 318, 318, 320, 320);
    send_tri();
    wait_done(d0 + 1, "t5_done");
    chk("t5_area", longint'(bus.o_tri_area), 1600);
    chk("t5_count", longint'(pop_cnt - p0), 4);
    chk("t5_sb_empty", longint'(sb.size()), 0);

    // 6: reset in the middle of a walk
    d0 = done_cnt; p0 = pop_cnt;
    push_t1();
    set_tri(0, 0, 4, 0, 0, 4, 0, 0, 4, 4);
    send_tri();
    for (int i = 0; i < 200; i++) begin
      if (pop_cnt - p0 >= 5) break;
      @(posedge clk); #1;
    end
    chk("t6_five_frags", longint'(pop_cnt - p0), 5);
    rstn = 1'b0;
    @(posedge clk); #1;
    chk("t6_valid_low", longint'(bus.o_frag_valid), 0);
    chk("t6_ready", longint'(bus.o_ready), 1);
    chk("t6_xy_zero", longint'(bus.o_frag_xy), 0);
    chk("t6_area_zero", longint'(bus.o_tri_area), 0);
    rstn = 1'b1;
    sb.delete();
    repeat (5) @(posedge clk);
    #1;
    chk("t6_no_done", longint'(done_cnt - d0), 0);
    run_t1("t6_after", 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
